spi_msg_sink: RTL and testbench

- Downstream consumer of one command-decoder destination channel: takes the byte stream (data_in, with a one-cycle data_valid per byte) and buffers it in an internal FIFO.
- Plays the buffered bytes out as one SPI mode-0 transaction per contiguous burst, keeping cs_n low across back-to-back bytes.
- Bytes sampled on miso are returned on rx_q/rx_valid for the reply path.
- The decoder has no backpressure, so buffering lives here.

---
 rtl/spi_msg_sink_if.sv | 23 ++
 rtl/spi_msg_sink.sv | 171 +++++++++++++++++
 tb/tb_spi_msg_sink.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_msg_sink_if.sv
// Byte-stream input, SPI pins, receive path and status of the SPI message sink.
interface spi_msg_sink_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       cs_n;
  logic [7:0] rx_q;
  logic       rx_valid;
  logic       busy;
  logic       overflow;

  modport master (
    output data_in, data_valid, miso,
    input  sck, mosi, cs_n, rx_q, rx_valid, busy, overflow
  );

  modport slave (
    input  data_in, data_valid, miso,
    output sck, mosi, cs_n, rx_q, rx_valid, busy, overflow
  );
endinterface

// File: rtl/spi_msg_sink.sv
// Buffers decoder bytes in a FIFO and plays each contiguous burst out as one SPI mode-0
// transaction; bytes sampled on miso come back on rx_q/rx_valid.
module spi_msg_sink #(
  parameter int CLK_DIV = 25,
  parameter int FIFO_AW = 8,
  parameter int GAP_CYC = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  spi_msg_sink_if.slave bus
);
  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam int              GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, push, pop;
  logic [7:0]       head;

  logic [7:0]    div_cnt;
  logic [2:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          div_last, gap_last;
  logic [7:0]    tx_sr, rx_sr, rx_q_r;
  logic          sck_r, mosi_r, cs_n_r, rx_valid_r, overflow_r;
  logic          rise, fall, end_byte, cs_on, cs_off;

  // Extra pointer MSB tells a full FIFO from an empty one after wrap-around.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign push       = bus.data_valid && (!fifo_full || pop);

  assign div_last = (div_cnt == DIV_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    end_byte = 1'b0;
    cs_on    = 1'b0;
    cs_off   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cs_on   = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          rise    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (div_last) begin
          if (!sck_r) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            // bit_cnt wraps to 0 after the 8th rise, so this fall closes the byte
            if (bit_cnt == 3'd0) begin
              end_byte = 1'b1;
              if (!fifo_empty) pop = 1'b1;
              else             state_n = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          cs_off  = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_q_r     <= '0;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      rx_valid_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;

      if ((state == SETUP || state == SHIFT || state == HOLD) && !div_last)
        div_cnt <= div_cnt + 8'd1;
      else
        div_cnt <= '0;

      if (state == GAP && !gap_last) gap_cnt <= gap_cnt + GW'(1);
      else                           gap_cnt <= '0;

      if (pop) begin
        tx_sr  <= head;
        mosi_r <= head[7];
      end else if (fall) begin
        tx_sr  <= {tx_sr[6:0], 1'b0};
        mosi_r <= tx_sr[6];
      end

      if (rise) begin
        sck_r   <= 1'b1;
        rx_sr   <= {rx_sr[6:0], bus.miso};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (fall) begin
        sck_r <= 1'b0;
      end

      if (end_byte) begin
        rx_q_r     <= rx_sr;
        rx_valid_r <= 1'b1;
      end

      if (cs_on)       cs_n_r <= 1'b0;
      else if (cs_off) cs_n_r <= 1'b1;

      if (bus.data_valid && !push) overflow_r <= 1'b1;
    end
  end

  assign bus.sck      = sck_r;
  assign bus.mosi     = mosi_r;
  assign bus.cs_n     = cs_n_r;
  assign bus.rx_q     = rx_q_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.overflow = overflow_r;
  assign bus.busy     = !fifo_empty || (state != IDLE);
endmodule

// File: tb/tb_spi_msg_sink.sv
// Directed and random traffic into spi_msg_sink with an SPI slave model; bus events are
// logged with cycle stamps and compared against byte order, reply data and timing rules.
module tb_spi_msg_sink;
  localparam int D   = 2;
  localparam int AW  = 2;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  spi_msg_sink_if bus();
  spi_msg_sink #(.CLK_DIV(D), .FIFO_AW(AW), .GAP_CYC(GAP)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  int cs_fall_t[$], cs_rise_t[$], rise_t[$], fall_t[$], rxv_t[$];
  logic [7:0] tx_obs[$], rx_obs[$], rx_exp[$];
  logic [7:0] exp_tx[$];
  bit fixed_en = 1'b0;
  logic [7:0] fixed_val = 8'h00;
  int ti = 0;
  int ri = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor plus mode-0 slave: miso only moves while sck is low.
  initial begin : monitor
    logic p_sck, p_cs, p_mosi, p_rxv;
    logic [7:0] sh, cur;
    int nb;
    p_sck = 0; p_cs = 1; p_mosi = 0; p_rxv = 0; sh = 0; cur = 0; nb = 0;
    bus.miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        nb = 0; p_sck = 0; p_cs = 1; p_mosi = 0; p_rxv = 0;
      end else begin
        if (p_cs && !bus.cs_n) begin
          cs_fall_t.push_back(cyc);
          nb = 0;
          cur = fixed_en ? fixed_val : 8'($urandom);
        end
        if (!p_cs && bus.cs_n) cs_rise_t.push_back(cyc);
        if (bus.sck != p_sck && bus.cs_n && p_cs) viol++;
        if (bus.mosi != p_mosi && !(p_sck && !bus.sck) && !(p_cs && !bus.cs_n)) viol++;
        if (!p_sck && bus.sck) begin
          rise_t.push_back(cyc);
          sh = {sh[6:0], bus.mosi};
          nb++;
          if (nb == 8) begin
            tx_obs.push_back(sh);
            rx_exp.push_back(cur);
            nb = 0;
            cur = fixed_en ? fixed_val : 8'($urandom);
          end
        end
        if (p_sck && !bus.sck) fall_t.push_back(cyc);
        if (bus.rx_valid) begin
          rxv_t.push_back(cyc);
          rx_obs.push_back(bus.rx_q);
          if (p_rxv) viol++;
        end
        p_sck = bus.sck; p_cs = bus.cs_n; p_mosi = bus.mosi; p_rxv = bus.rx_valid;
      end
      if (!bus.sck) bus.miso = cur[3'(7 - nb)];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in = b;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || !bus.cs_n) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, ":idle_timeout"}, 32'(n < 3000), 1);
  endtask

  // Transmitted bytes must equal accepted bytes in order; replies must match the slave.
  task automatic check_streams(input string tag);
    chk({tag, ":tx_count"}, 32'(tx_obs.size()), 32'(exp_tx.size()));
    while (ti < tx_obs.size() && ti < exp_tx.size()) begin
      chk({tag, ":tx_byte"}, 32'(tx_obs[ti]), 32'(exp_tx[ti]));
      ti++;
    end
    chk({tag, ":rx_count"}, 32'(rx_obs.size()), 32'(rx_exp.size()));
    while (ri < rx_obs.size() && ri < rx_exp.size()) begin
      chk({tag, ":rx_byte"}, 32'(rx_obs[ri]), 32'(rx_exp[ri]));
      ri++;
    end
  endtask

  initial begin
    int e0, n, i_csf, i_csr, i_r, i_f, i_rx, busy_low;
    logic [7:0] b;
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(bus.sck), 0);
    chk("rst_cs_n", 32'(bus.cs_n), 1);
    chk("rst_mosi", 32'(bus.mosi), 0);
    chk("rst_rx_q", 32'(bus.rx_q), 0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5, slave answers 0x3C
    fixed_en = 1'b1; fixed_val = 8'h3C;
    i_csf = cs_fall_t.size(); i_csr = cs_rise_t.size(); i_r = rise_t.size();
    i_f = fall_t.size(); i_rx = rxv_t.size();
    e0 = cyc + 1;
    send(8'hA5); exp_tx.push_back(8'hA5);
    wait_idle("single");
    fixed_en = 1'b0;
    chk("single:rises", 32'(rise_t.size() - i_r), 8);
    chk("single:rx_pulses", 32'(rxv_t.size() - i_rx), 1);
    if (cs_fall_t.size() > i_csf) chk("single:cs_fall_t", 32'(cs_fall_t[i_csf]), 32'(e0 + 1));
    if (rise_t.size() > i_r) chk("single:first_rise_t", 32'(rise_t[i_r]), 32'(e0 + 1 + D));
    if (fall_t.size() > i_f + 7) chk("single:last_fall_t", 32'(fall_t[i_f + 7]), 32'(e0 + 1 + 16 * D));
    if (rxv_t.size() > i_rx) chk("single:rx_valid_t", 32'(rxv_t[i_rx]), 32'(e0 + 1 + 16 * D));
    if (cs_rise_t.size() > i_csr) chk("single:cs_rise_t", 32'(cs_rise_t[i_csr]), 32'(e0 + 1 + 17 * D));
    if (rx_obs.size() > ri) chk("single:rx_3c", 32'(rx_obs[ri]), 32'h3C);
    check_streams("single");

    // four-byte burst in one window
    i_csf = cs_fall_t.size(); i_r = rise_t.size(); i_rx = rxv_t.size();
    for (int k = 1; k <= 4; k++) begin
      send(8'(k));
      exp_tx.push_back(8'(k));
    end
    wait_idle("burst");
    chk("burst:windows", 32'(cs_fall_t.size() - i_csf), 1);
    chk("burst:rises", 32'(rise_t.size() - i_r), 32);
    chk("burst:rx_pulses", 32'(rxv_t.size() - i_rx), 4);
    for (int k = 1; k < 4; k++)
      if (rxv_t.size() > i_rx + k)
        chk("burst:rx_spacing", 32'(rxv_t[i_rx + k] - rxv_t[i_rx + k - 1]), 32'(16 * D));
    check_streams("burst");

    // write landing in the GAP phase
    i_csf = cs_fall_t.size(); i_csr = cs_rise_t.size();
    b = 8'($urandom); send(b); exp_tx.push_back(b);
    n = 0;
    while (bus.cs_n && n < 100) begin @(negedge clk); n++; end
    while (!bus.cs_n && n < 400) begin @(negedge clk); n++; end
    b = 8'($urandom); send(b); exp_tx.push_back(b);
    busy_low = 0;
    while (bus.cs_n && n < 500) begin
      if (!bus.busy) busy_low++;
      @(negedge clk);
      n++;
    end
    wait_idle("gap");
    chk("gap:busy_held", 32'(busy_low), 0);
    chk("gap:windows", 32'(cs_fall_t.size() - i_csf), 2);
    if (cs_fall_t.size() > i_csf + 1 && cs_rise_t.size() > i_csr)
      chk("gap:cs_high_len", 32'(cs_fall_t[i_csf + 1] - cs_rise_t[i_csr]), 32'(GAP + 1));
    check_streams("gap");

    // write coinciding with the end-of-byte pop of the last queued byte
    i_csf = cs_fall_t.size(); i_rx = rxv_t.size();
    e0 = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom); send(b); exp_tx.push_back(b);
    end
    n = 0;
    while (cyc < e0 + 16 * D && n < 200) begin @(negedge clk); n++; end
    b = 8'($urandom); send(b); exp_tx.push_back(b);
    wait_idle("eob");
    chk("eob:windows", 32'(cs_fall_t.size() - i_csf), 1);
    chk("eob:rx_pulses", 32'(rxv_t.size() - i_rx), 3);
    if (rxv_t.size() > i_rx) chk("eob:first_end_t", 32'(rxv_t[i_rx]), 32'(e0 + 1 + 16 * D));
    check_streams("eob");

    // random bursts of 1..4 bytes with short random spacing
    for (int r = 0; r < 10; r++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom); send(b); exp_tx.push_back(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("random");
      check_streams("random");
    end
    chk("random:overflow_clear", 32'(bus.overflow), 0);

    // six writes into a four-deep FIFO: the last one is dropped
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom); send(b);
      if (k < 5) exp_tx.push_back(b);
      if (k == 4) chk("ovf:before_drop", 32'(bus.overflow), 0);
    end
    chk("ovf:after_drop", 32'(bus.overflow), 1);
    wait_idle("ovf");
    check_streams("ovf");
    b = 8'($urandom); send(b); exp_tx.push_back(b);
    wait_idle("ovf_sticky");
    chk("ovf:sticky", 32'(bus.overflow), 1);
    check_streams("ovf_sticky");

    // reset in the middle of bit 3 with one more byte queued
    i_r = rise_t.size();
    send(8'($urandom)); send(8'($urandom));
    n = 0;
    while (rise_t.size() < i_r + 3 && n < 500) begin @(negedge clk); n++; end
    chk("rst:reached_bit3", 32'(rise_t.size() >= i_r + 3), 1);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("rst:sck", 32'(bus.sck), 0);
    chk("rst:cs_n", 32'(bus.cs_n), 1);
    chk("rst:mosi", 32'(bus.mosi), 0);
    chk("rst:busy", 32'(bus.busy), 0);
    chk("rst:overflow", 32'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    i_csf = cs_fall_t.size(); i_r = rise_t.size(); i_rx = rxv_t.size();
    repeat (60) @(negedge clk);
    chk("rst:no_cs", 32'(cs_fall_t.size() - i_csf), 0);
    chk("rst:no_sck", 32'(rise_t.size() - i_r), 0);
    chk("rst:no_rx", 32'(rxv_t.size() - i_rx), 0);
    chk("rst:idle_busy", 32'(bus.busy), 0);
    b = 8'($urandom); send(b); exp_tx.push_back(b);
    wait_idle("post_rst");
    check_streams("post_rst");

    chk("protocol_violations", 32'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
